// File: rtl/i2s_pkg.sv
// Shared types and constants for the uDMA I2S RX sample arbiter.
package i2s_pkg;

    typedef enum logic {
        I2S_ARB_RR  = 1'b0,
        I2S_ARB_SEQ = 1'b1
    } i2s_arb_mode_e;

    localparam logic [1:0] I2S_DATASIZE_8  = 2'd0;
    localparam logic [1:0] I2S_DATASIZE_16 = 2'd1;
    localparam logic [1:0] I2S_DATASIZE_32 = 2'd2;

    // Channel index following i, wrapping from n-1 back to 0.
    function automatic int unsigned wrap_next(input int unsigned i, input int unsigned n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/udma_i2s_rr_pick.sv
// Combinational circular first-set-bit search starting at a given index.
module udma_i2s_rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  vec_i,
    input  logic [IW-1:0] start_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    int unsigned pos;

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        pos     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = (32'(start_i) + k) % N;
            if (!found_o && vec_i[pos[IW-1:0]]) begin
                found_o = 1'b1;
                idx_o   = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/udma_i2s_rx_arbiter.sv
// Arbitrates NB_CH I2S RX sample streams onto one uDMA RX channel, round-robin
// or in strict channel sequence, through a single tagged output register stage.
module udma_i2s_rx_arbiter
    import i2s_pkg::*;
#(
    parameter int unsigned NB_CH = 4,
    parameter int unsigned DW    = 32
) (
    input  logic                     sys_clk_i,
    input  logic                     rstn_i,
    input  logic                     cfg_en_i,
    input  logic                     cfg_mode_i,
    input  logic [NB_CH-1:0]         cfg_ch_mask_i,
    input  logic [NB_CH*DW-1:0]      in_data_i,
    input  logic [NB_CH*2-1:0]       in_datasize_i,
    input  logic [NB_CH-1:0]         in_valid_i,
    output logic [NB_CH-1:0]         in_ready_o,
    output logic [DW-1:0]            out_data_o,
    output logic [1:0]               out_datasize_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [$clog2(NB_CH)-1:0] out_ch_o,
    output logic                     busy_o
);

    localparam int unsigned CW = $clog2(NB_CH);

    logic [CW-1:0]    ptr_q, ptr_d, ptr_eff, ptr_nxt_start;
    logic             en_q, en_d, en_rise;
    logic [DW-1:0]    out_data_q, out_data_d;
    logic [1:0]       out_datasize_q, out_datasize_d;
    logic             out_valid_q, out_valid_d;
    logic [CW-1:0]    out_ch_q, out_ch_d;

    logic [NB_CH-1:0] cand;
    logic             ld, grant;
    logic [CW-1:0]    gidx;
    logic [CW-1:0]    rr_idx, nxt_idx, low_idx;
    logic             rr_found, nxt_found, low_found;
    i2s_arb_mode_e    mode;

    assign cand    = in_valid_i & cfg_ch_mask_i;
    assign en_rise = cfg_en_i & ~en_q;
    // On the enable edge the decision starts from the lowest enabled channel.
    assign ptr_eff = en_rise ? low_idx : ptr_q;
    assign ptr_nxt_start = CW'(wrap_next(32'(ptr_eff), NB_CH));
    assign mode    = i2s_arb_mode_e'(cfg_mode_i);
    assign ld      = rstn_i & cfg_en_i & (~out_valid_q | out_ready_i);

    udma_i2s_rr_pick #(.N(NB_CH), .IW(CW)) u_pick_rr (
        .vec_i   (cand),
        .start_i (ptr_eff),
        .idx_o   (rr_idx),
        .found_o (rr_found)
    );

    udma_i2s_rr_pick #(.N(NB_CH), .IW(CW)) u_pick_seq (
        .vec_i   (cfg_ch_mask_i),
        .start_i (ptr_nxt_start),
        .idx_o   (nxt_idx),
        .found_o (nxt_found)
    );

    udma_i2s_rr_pick #(.N(NB_CH), .IW(CW)) u_pick_low (
        .vec_i   (cfg_ch_mask_i),
        .start_i ('0),
        .idx_o   (low_idx),
        .found_o (low_found)
    );

    always_comb begin
        grant = 1'b0;
        gidx  = ptr_eff;
        ptr_d = ptr_eff;
        en_d  = cfg_en_i;
        if (cfg_en_i) begin
            if (mode == I2S_ARB_RR) begin
                if (ld && rr_found) begin
                    grant = 1'b1;
                    gidx  = rr_idx;
                    ptr_d = CW'(wrap_next(32'(rr_idx), NB_CH));
                end
            end else if (!cfg_ch_mask_i[ptr_eff]) begin
                // Disabled channel under the pointer: skip ahead without granting.
                if (nxt_found) ptr_d = nxt_idx;
            end else if (ld && cand[ptr_eff]) begin
                grant = 1'b1;
                gidx  = ptr_eff;
                ptr_d = nxt_idx;
            end
        end
        if (!low_found && en_rise && !grant) ptr_d = '0;
    end

    always_comb begin
        in_ready_o = '0;
        if (grant) in_ready_o[gidx] = 1'b1;
    end

    always_comb begin
        out_data_d     = out_data_q;
        out_datasize_d = out_datasize_q;
        out_ch_d       = out_ch_q;
        out_valid_d    = out_valid_q;
        if (grant) begin
            out_data_d     = in_data_i[gidx*DW +: DW];
            out_datasize_d = in_datasize_i[gidx*2 +: 2];
            out_ch_d       = gidx;
            out_valid_d    = 1'b1;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (!rstn_i) begin
            ptr_q          <= '0;
            en_q           <= 1'b0;
            out_data_q     <= '0;
            out_datasize_q <= I2S_DATASIZE_8;
            out_ch_q       <= '0;
            out_valid_q    <= 1'b0;
        end else begin
            ptr_q          <= ptr_d;
            en_q           <= en_d;
            out_data_q     <= out_data_d;
            out_datasize_q <= out_datasize_d;
            out_ch_q       <= out_ch_d;
            out_valid_q    <= out_valid_d;
        end
    end

    assign out_data_o     = out_data_q;
    assign out_datasize_o = out_datasize_q;
    assign out_valid_o    = out_valid_q;
    assign out_ch_o       = out_ch_q;
    assign busy_o         = out_valid_q | (|cand);

endmodule

// File: tb/tb_udma_i2s_rx_arbiter.sv
// Scoreboard bench for udma_i2s_rx_arbiter: directed stimulus pushes expected
// samples, a negedge monitor pops them on every output handshake.
module tb_udma_i2s_rx_arbiter;
    import i2s_pkg::*;

    localparam int NB_CH = 4;
    localparam int DW    = 32;

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] data;
        logic [1:0]  ds;
    } exp_t;

    logic              clk = 1'b0;
    logic              rstn, cfg_en, cfg_mode, out_ready, out_valid, busy;
    logic [3:0]        cfg_mask, in_valid, in_ready;
    logic [127:0]      in_data;
    logic [7:0]        in_ds;
    logic [31:0]       out_data;
    logic [1:0]        out_ds, out_ch;
    logic [31:0]       ch_data [4];
    logic [1:0]        ch_ds [4];

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    always_comb begin
        in_data = '0;
        in_ds   = '0;
        for (int i = 0; i < 4; i++) begin
            in_data[i*32 +: 32] = ch_data[i];
            in_ds[i*2 +: 2]     = ch_ds[i];
        end
    end

    udma_i2s_rx_arbiter #(.NB_CH(NB_CH), .DW(DW)) dut (
        .sys_clk_i      (clk),
        .rstn_i         (rstn),
        .cfg_en_i       (cfg_en),
        .cfg_mode_i     (cfg_mode),
        .cfg_ch_mask_i  (cfg_mask),
        .in_data_i      (in_data),
        .in_datasize_i  (in_ds),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .out_data_o     (out_data),
        .out_datasize_o (out_ds),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_ch_o       (out_ch),
        .busy_o         (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch);
        exp_t e;
        e.ch   = 2'(ch);
        e.data = ch_data[ch];
        e.ds   = ch_ds[ch];
        sb.push_back(e);
    endtask

    task automatic do_reset(input logic mode, input logic [3:0] mask);
        step();
        step();
        rstn     = 1'b0;
        cfg_mode = mode;
        cfg_mask = mask;
        cfg_en   = 1'b1;
        in_valid = 4'h0;
        out_ready = 1'b1;
        step();
        step();
        rstn = 1'b1;
    endtask

    // Monitor: every accepted output sample must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstn && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got ch=%0d data=%h expected no sample", out_ch, out_data);
                end else begin
                    e = sb.pop_front();
                    chk("out_ch", 32'(out_ch), 32'(e.ch));
                    chk("out_data", out_data, e.data);
                    chk("out_datasize", 32'(out_ds), 32'(e.ds));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            ch_data[i] = 32'hC0DE_0000 + 32'(i) * 32'h0101;
            ch_ds[i]   = I2S_DATASIZE_32;
        end
        rstn      = 1'b0;
        cfg_en    = 1'b1;
        cfg_mode  = 1'b0;
        cfg_mask  = 4'hF;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ds", 32'(out_ds), 0);
        chk("rst_out_ch", 32'(out_ch), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        in_valid = 4'h0;
        rstn = 1'b1;

        // 1: round-robin over all channels, one grant per cycle
        do_reset(1'b0, 4'hF);
        for (int i = 0; i < 8; i++) push(i % 4);
        in_valid = 4'hF;
        repeat (8) step();
        in_valid = 4'h0;

        // 2: strict sequence waits on ch0 even though ch2 is ready
        do_reset(1'b1, 4'b0101);
        in_valid = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("seq_wait_ready", 32'(in_ready), 0);
            step();
            chk("seq_wait_valid", 32'(out_valid), 0);
        end
        push(0); push(2); push(0);
        in_valid = 4'b0101;
        repeat (3) step();
        in_valid = 4'h0;

        // 3: stall holds the output and blocks grants
        do_reset(1'b0, 4'hF);
        ch_data[1] = 32'hDEAD_BEEF;
        out_ready  = 1'b0;
        push(1);
        in_valid = 4'b0010;
        step();
        in_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_in_ready", 32'(in_ready), 0);
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_data", out_data, 32'hDEAD_BEEF);
            chk("stall_ch", 32'(out_ch), 1);
            step();
        end
        out_ready = 1'b1;
        push(0);
        #1;
        chk("unstall_ready", 32'(in_ready), 32'h1);
        step();
        in_valid = 4'h0;

        // 4: lone ch3 from ptr 0, pointer wraps to 0, datasize passes through
        do_reset(1'b0, 4'hF);
        ch_data[3] = 32'h0000_BEEF;
        ch_ds[3]   = I2S_DATASIZE_16;
        push(3);
        in_valid = 4'b1000;
        step();
        push(0);
        in_valid = 4'b1001;
        step();
        in_valid = 4'h0;

        // 5: disable drains the pending sample; re-enable restarts at lowest mask bit
        do_reset(1'b0, 4'hF);
        out_ready = 1'b0;
        push(2);
        in_valid = 4'b0100;
        step();
        in_valid  = 4'hF;
        cfg_en    = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("dis_in_ready", 32'(in_ready), 0);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("dis_valid", 32'(out_valid), 0);
            chk("dis_in_ready2", 32'(in_ready), 0);
            step();
        end
        cfg_mode = 1'b1;
        cfg_mask = 4'b1100;
        cfg_en   = 1'b1;
        push(2); push(3);
        #1;
        chk("reen_ready", 32'(in_ready), 32'h4);
        step();
        step();
        in_valid = 4'h0;

        // 6: reset during a stall discards the pending sample
        do_reset(1'b0, 4'hF);
        out_ready = 1'b0;
        in_valid  = 4'b0010;
        step();
        in_valid = 4'h0;
        rstn     = 1'b0;
        step();
        chk("rst6_valid", 32'(out_valid), 0);
        chk("rst6_data", out_data, 0);
        chk("rst6_ch", 32'(out_ch), 0);
        rstn      = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst6_idle", 32'(out_valid), 0);
        end
        push(0);
        in_valid = 4'b1001;
        step();
        in_valid = 4'h0;

        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        chk("sb_empty", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
